morse_tx_ctrl: RTL and testbench

Parametrised Morse transmitter. It drives a single LED/tone line with the full ITU alphabet: A–Z and digits 0–9, selected by a 6-bit code. Symbol rate and word gap are parameters. The block adds start/abort/repeat control and busy/done/err status, and sits between board switches/keys and an LED output.

---
 rtl/morse_tx_ctrl_if.sv | 21 ++
 rtl/morse_tx_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_morse_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_tx_ctrl_if.sv
// rtl/morse_tx_ctrl_if.sv - control/status bundle between keys/switches and the Morse transmitter
interface morse_tx_ctrl_if;
    logic [5:0] sel;
    logic       start;
    logic       abort;
    logic       repeat_en;
    logic       led;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output sel, start, abort, repeat_en,
        input  led, busy, done, err
    );

    modport slave (
        input  sel, start, abort, repeat_en,
        output led, busy, done, err
    );
endinterface

// File: rtl/morse_tx_ctrl.sv
// rtl/morse_tx_ctrl.sv - parametrised Morse transmitter for A-Z and 0-9 with repeat/abort control
module morse_tx_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int SYMBOL_HZ = 2,
    parameter int WORD_GAP  = 7
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    morse_tx_ctrl_if.slave  bus
);
    localparam int DIV = CLK_HZ / SYMBOL_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [3:0]    GAP_LAST = 4'(WORD_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    // Element table: count of elements plus dash mask (first element in bit 4),
    // expanded into a left-aligned on/off pattern and its length in units.
    function automatic logic [23:0] rom(input logic [5:0] code);
        logic [2:0]  n;
        logic [4:0]  m;
        logic [18:0] acc;
        logic [4:0]  len;
        case (code)
            6'd0:  {n, m} = {3'd2, 5'b01000};
            6'd1:  {n, m} = {3'd4, 5'b10000};
            6'd2:  {n, m} = {3'd4, 5'b10100};
            6'd3:  {n, m} = {3'd3, 5'b10000};
            6'd4:  {n, m} = {3'd1, 5'b00000};
            6'd5:  {n, m} = {3'd4, 5'b00100};
            6'd6:  {n, m} = {3'd3, 5'b11000};
            6'd7:  {n, m} = {3'd4, 5'b00000};
            6'd8:  {n, m} = {3'd2, 5'b00000};
            6'd9:  {n, m} = {3'd4, 5'b01110};
            6'd10: {n, m} = {3'd3, 5'b10100};
            6'd11: {n, m} = {3'd4, 5'b01000};
            6'd12: {n, m} = {3'd2, 5'b11000};
            6'd13: {n, m} = {3'd2, 5'b10000};
            6'd14: {n, m} = {3'd3, 5'b11100};
            6'd15: {n, m} = {3'd4, 5'b01100};
            6'd16: {n, m} = {3'd4, 5'b11010};
            6'd17: {n, m} = {3'd3, 5'b01000};
            6'd18: {n, m} = {3'd3, 5'b00000};
            6'd19: {n, m} = {3'd1, 5'b10000};
            6'd20: {n, m} = {3'd3, 5'b00100};
            6'd21: {n, m} = {3'd4, 5'b00010};
            6'd22: {n, m} = {3'd3, 5'b01100};
            6'd23: {n, m} = {3'd4, 5'b10010};
            6'd24: {n, m} = {3'd4, 5'b10110};
            6'd25: {n, m} = {3'd4, 5'b11000};
            6'd26: {n, m} = {3'd5, 5'b11111};
            6'd27: {n, m} = {3'd5, 5'b01111};
            6'd28: {n, m} = {3'd5, 5'b00111};
            6'd29: {n, m} = {3'd5, 5'b00011};
            6'd30: {n, m} = {3'd5, 5'b00001};
            6'd31: {n, m} = {3'd5, 5'b00000};
            6'd32: {n, m} = {3'd5, 5'b10000};
            6'd33: {n, m} = {3'd5, 5'b11000};
            6'd34: {n, m} = {3'd5, 5'b11100};
            6'd35: {n, m} = {3'd5, 5'b11110};
            default: {n, m} = 8'd0;
        endcase
        acc = '0;
        len = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < int'(n)) begin
                if (i > 0) begin
                    acc = {acc[17:0], 1'b0};
                    len = len + 5'd1;
                end
                if (m[4-i]) begin
                    acc = {acc[15:0], 3'b111};
                    len = len + 5'd3;
                end else begin
                    acc = {acc[17:0], 1'b1};
                    len = len + 5'd1;
                end
            end
        end
        acc = acc << (5'd19 - len);
        return {acc, len};
    endfunction

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    gap_q, gap_d;
    logic [18:0]   pat_q, pat_d;
    logic [4:0]    rem_q, rem_d;
    logic [18:0]   lat_pat_q, lat_pat_d;
    logic [4:0]    lat_len_q, lat_len_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tick;
    logic [23:0]   rom_v;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        pat_d     = pat_q;
        rem_d     = rem_q;
        lat_pat_d = lat_pat_q;
        lat_len_d = lat_len_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rom_v     = rom(bus.sel);
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (bus.start) begin
                    if (bus.sel < 6'd36) begin
                        lat_pat_d = rom_v[23:5];
                        lat_len_d = rom_v[4:0];
                        pat_d     = rom_v[23:5];
                        rem_d     = rom_v[4:0];
                        state_d   = S_SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (tick) begin
                    if (rem_q == 5'd1) begin
                        if (bus.repeat_en) begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        pat_d = {pat_q[17:0], 1'b0};
                        rem_d = rem_q - 5'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        if (bus.repeat_en) begin
                            pat_d   = lat_pat_q;
                            rem_d   = lat_len_q;
                            state_d = S_SEND;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort beats any start or completion decided above
        if (bus.abort) begin
            state_d = S_IDLE;
            div_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        led_d  = (state_d == S_SEND) && pat_d[18];
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            gap_q     <= '0;
            pat_q     <= '0;
            rem_q     <= '0;
            lat_pat_q <= '0;
            lat_len_q <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            gap_q     <= gap_d;
            pat_q     <= pat_d;
            rem_q     <= rem_d;
            lat_pat_q <= lat_pat_d;
            lat_len_q <= lat_len_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_morse_tx_ctrl.sv
// tb/tb_morse_tx_ctrl.sv - directed bench with a timeline model of the Morse transmitter
module tb_morse_tx_ctrl;
    localparam int DIV  = 4;
    localparam int WG   = 7;
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    morse_tx_ctrl_if u_if ();

    morse_tx_ctrl #(.CLK_HZ(8), .SYMBOL_HZ(2), .WORD_GAP(WG)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (u_if)
    );

    string morse_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                              "-----", ".----", "..---", "...--", "....-", ".....",
                              "-....", "--...", "---..", "----."};

    // expected {led, busy, done, err} for each cycle of the current scenario
    logic [3:0] exp_v [MAXC];
    bit         pat_bits [$];
    int         cyc;
    bit         chk_en;
    int         checks;
    int         errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [3:0] e;
        e = (cyc < MAXC) ? exp_v[cyc] : 4'd0;
        chk("led",  32'(u_if.led),  32'(e[3]));
        chk("busy", 32'(u_if.busy), 32'(e[2]));
        chk("done", 32'(u_if.done), 32'(e[1]));
        chk("err",  32'(u_if.err),  32'(e[0]));
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) compare_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic build(input int code);
        string s;
        s = morse_tab[code];
        pat_bits.delete();
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) pat_bits.push_back(1'b0);
            if (s[i] == "-") begin
                pat_bits.push_back(1'b1);
                pat_bits.push_back(1'b1);
                pat_bits.push_back(1'b1);
            end else begin
                pat_bits.push_back(1'b1);
            end
        end
    endtask

    function automatic logic [18:0] packed_pat();
        logic [18:0] v;
        v = '0;
        for (int i = 0; i < pat_bits.size(); i++) v[18-i] = pat_bits[i];
        return v;
    endfunction

    task automatic put(input int c, input logic [3:0] v);
        if (c >= 0 && c < MAXC) exp_v[c] = exp_v[c] | v;
    endtask

    // n patterns of code started at t; trail = a gap follows the last pattern
    task automatic plan_tx(input int t, input int code, input int n, input bit trail);
        int base;
        int len;
        build(code);
        len  = pat_bits.size();
        base = t + 1;
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < len; k++)
                for (int d = 0; d < DIV; d++)
                    put(base + k*DIV + d, {pat_bits[k], 1'b1, 2'b00});
            base += len * DIV;
            if (p < n - 1 || trail) begin
                for (int d = 0; d < WG*DIV; d++) put(base + d, 4'b0100);
                base += WG * DIV;
            end
        end
        put(base, 4'b0010);
    endtask

    task automatic truncate(input int c);
        for (int i = c; i < MAXC; i++) exp_v[i] = 4'd0;
    endtask

    task automatic begin_scn();
        chk_en = 1'b0;
        reset = 1'b1;
        u_if.sel = '0;
        u_if.start = 1'b0;
        u_if.abort = 1'b0;
        u_if.repeat_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < MAXC; i++) exp_v[i] = 4'd0;
        cyc = 0;
        chk_en = 1'b1;
    endtask

    task automatic pulse_start(input int code);
        u_if.sel = 6'(code);
        u_if.start = 1'b1;
        step();
        u_if.start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        chk_en = 1'b0;

        build(0);
        chk("model_A_pat", 32'(packed_pat()), 32'(19'b1011100000000000000));
        chk("model_A_len", 32'(pat_bits.size()), 32'd5);
        build(9);
        chk("model_J_pat", 32'(packed_pat()), 32'(19'b1011101110111000000));
        build(26);
        chk("model_0_pat", 32'(packed_pat()), 32'(19'b1110111011101110111));

        // A, single shot
        begin_scn();
        chk("reset_state", 32'({u_if.led, u_if.busy, u_if.done, u_if.err}), 32'd0);
        plan_tx(0, 0, 1, 1'b0);
        pulse_start(0);
        run_to(20);
        chk("A_led_c20", 32'(u_if.led), 32'd1);
        run_to(21);
        chk("A_done_c21", 32'({u_if.done, u_if.busy, u_if.led}), 32'b100);
        run_to(25);

        // E with repeat, dropped at cycle 40
        begin_scn();
        plan_tx(0, 4, 2, 1'b1);
        u_if.repeat_en = 1'b1;
        pulse_start(4);
        run_to(10);
        u_if.sel = 6'd0;
        run_to(33);
        chk("E_rep_led_c33", 32'(u_if.led), 32'd1);
        run_to(40);
        u_if.repeat_en = 1'b0;
        run_to(65);
        chk("E_done_c65", 32'(u_if.done), 32'd1);
        run_to(70);

        // invalid code
        begin_scn();
        put(1, 4'b0001);
        pulse_start(40);
        chk("err_c1", 32'({u_if.err, u_if.busy, u_if.led, u_if.done}), 32'b1000);
        run_to(5);

        // digit 0, longest pattern
        begin_scn();
        plan_tx(0, 26, 1, 1'b0);
        pulse_start(26);
        run_to(1 + 19*DIV);
        chk("zero_done", 32'(u_if.done), 32'd1);
        run_to(80);

        // J ignores start while busy, then back-to-back E on the done cycle
        begin_scn();
        plan_tx(0, 9, 1, 1'b0);
        plan_tx(53, 4, 1, 1'b0);
        pulse_start(9);
        run_to(10);
        pulse_start(0);
        run_to(20);
        pulse_start(50);
        run_to(53);
        chk("J_done_c53", 32'(u_if.done), 32'd1);
        pulse_start(4);
        run_to(58);
        chk("E_b2b_done_c58", 32'(u_if.done), 32'd1);
        run_to(62);

        // abort mid-dash, abort beats start, then clean restart
        begin_scn();
        plan_tx(0, 0, 1, 1'b0);
        truncate(13);
        plan_tx(24, 0, 1, 1'b0);
        pulse_start(0);
        run_to(12);
        u_if.abort = 1'b1;
        step();
        u_if.abort = 1'b0;
        chk("abort_c13", 32'({u_if.led, u_if.busy}), 32'd0);
        run_to(20);
        u_if.abort = 1'b1;
        pulse_start(0);
        u_if.abort = 1'b0;
        run_to(24);
        pulse_start(0);
        run_to(25);
        chk("restart_led_c25", 32'(u_if.led), 32'd1);
        run_to(50);

        // reset mid-pattern
        begin_scn();
        plan_tx(0, 0, 1, 1'b0);
        truncate(7);
        plan_tx(10, 0, 1, 1'b0);
        pulse_start(0);
        run_to(6);
        reset = 1'b1;
        run_to(8);
        reset = 1'b0;
        run_to(10);
        pulse_start(0);
        run_to(35);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
